// File: rtl/inst_queue.sv
// Dual-issue instruction queue between fetch and decode: circular buffer of
// instruction/PC pairs, two-wide enqueue, 0..2 in-order dequeue, sync flush.
module inst_queue #(
    parameter int DEPTH  = 8,
    parameter int INST_W = 32,
    parameter int PC_W   = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    input  logic [PC_W-1:0]           in_pc,
    input  logic [INST_W-1:0]         inst1,
    input  logic [INST_W-1:0]         inst2,
    output logic                      in_ready,
    input  logic                      flush,
    input  logic [1:0]                deq_count,
    output logic                      out0_valid,
    output logic [INST_W-1:0]         out0_inst,
    output logic [PC_W-1:0]           out0_pc,
    output logic                      out1_valid,
    output logic [INST_W-1:0]         out1_inst,
    output logic [PC_W-1:0]           out1_pc,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem   [DEPTH];

    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW-1:0] head1, tail1;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    deq_req, deq;
    logic          enq;

    assign head1 = head_q + AW'(1);
    assign tail1 = tail_q + AW'(1);

    // Ready looks only at the registered count; a same-cycle dequeue never frees room.
    assign in_ready = (count_q <= CW'(DEPTH - 2));
    assign enq      = in_valid & in_ready & ~flush;

    always_comb begin
        deq_req = (deq_count == 2'd3) ? 2'd2 : deq_count;
        deq     = deq_req;
        if (count_q == '0) begin
            deq = 2'd0;
        end else if (count_q == CW'(1) && deq_req == 2'd2) begin
            deq = 2'd1;
        end
    end

    always_comb begin
        head_d  = head_q + AW'(deq);
        tail_d  = enq ? (tail_q + AW'(2)) : tail_q;
        count_d = count_q - CW'(deq) + (enq ? CW'(2) : CW'(0));
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; contents are only observed behind the valid flags.
    always_ff @(posedge clk) begin
        if (enq) begin
            inst_mem[tail_q] <= inst1;
            pc_mem[tail_q]   <= in_pc;
            inst_mem[tail1]  <= inst2;
            pc_mem[tail1]    <= in_pc + PC_W'(4);
        end
    end

    always_comb begin
        out0_valid = (count_q != '0);
        out1_valid = (count_q >= CW'(2));
        out0_inst  = out0_valid ? inst_mem[head_q] : '0;
        out0_pc    = out0_valid ? pc_mem[head_q]   : '0;
        out1_inst  = out1_valid ? inst_mem[head1]  : '0;
        out1_pc    = out1_valid ? pc_mem[head1]    : '0;
    end

    assign occupancy = count_q;

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Dual-issue instruction queue directly downstream of the fetch stage.
- Each cycle it captures the pair of 32-bit instructions that fetch produces, together with their PCs, into a circular buffer.
- It presents up to two oldest instructions per cycle to decode.
- It back-pressures PC generation when fewer than two slots are free, and supports a single-cycle flush for branch redirect.

Parameters:
- DEPTH, 8, number of instruction entries; power of two, at least 4.
- INST_W, 32, instruction width in bits.
- PC_W, 8, byte-address PC width, matching the fetch memory address.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  inst1/inst2 hold a valid fetched pair this cycle. PC generation drives this one cycle after issuing the PC, matching fetch's 1-cycle latency.
- in_pc  input  PC_W  byte PC of inst1. The PC of inst2 is in_pc+4, mod 2^PC_W.
- inst1  input  INST_W  older instruction of the pair, from fetch.
- inst2  input  INST_W  younger instruction of the pair, from fetch.
- in_ready  output  1  queue can accept a full pair this cycle.
- flush  input  1  discard all queued and incoming instructions.
- deq_count  input  2  number of instructions decode consumes this cycle (0..2; 3 treated as 2).
- out0_valid  output  1  head entry valid.
- out0_inst  output  INST_W  head instruction.
- out0_pc  output  PC_W  head PC.
- out1_valid  output  1  second entry valid.
- out1_inst  output  INST_W  second instruction.
- out1_pc  output  PC_W  second PC.
- occupancy  output  log2(DEPTH)+1  current entry count.

Behaviour:
State:
- Storage array DEPTH x (INST_W+PC_W).
- head and tail pointers, log2(DEPTH) bits each, wrapping mod DEPTH.
- count register, 0..DEPTH.

Reset (async, reset_n=0):
- head=tail=count=0.
- in_ready=1; out0_valid=out1_valid=0; occupancy=0.
- Storage is not reset.

in_ready:
- Combinational from registered count only: in_ready = (DEPTH-count >= 2).
- No bypass of the same-cycle dequeue.

Enqueue:
- When in_valid & in_ready & !flush: write inst1/in_pc at tail, and inst2/(in_pc+4) at tail+1 (mod DEPTH); tail += 2.
- in_valid while in_ready=0 is dropped. PC generation must hold its PC; this is the stall contract.

Outputs:
- Combinational from head: out0 = entry[head], valid iff count>=1; out1 = entry[head+1], valid iff count>=2.
- Inst/pc outputs are driven to 0 when the corresponding valid is 0.

Dequeue:
- deq = min(deq_count clamped to 2, count); head += deq.
- Decode may only take in order: out0 before out1.

Simultaneous enqueue and dequeue:
- count_next = count - deq + enq (enq is 0 or 2).
- Both apply in the same cycle.
- Enqueue into a slot freed in that same cycle is not permitted, since in_ready ignores deq.

Flush:
- Synchronous and highest priority: head=tail=count=0 next cycle.
- The same-cycle enqueue and dequeue are ignored.
- Outputs are invalid the following cycle.

Latency:
- An instruction pair enqueued at edge N is visible on out0/out1 after edge N when the queue was empty (0-cycle internal bypass is not provided).

Wrap-around:
- Pointer arithmetic wraps silently.
- A pair may straddle entry DEPTH-1 and entry 0.
- PC+4 wraps mod 2^PC_W with no flag.

Odd occupancy:
- Single dequeues can leave count odd. in_ready is then low at count=DEPTH-1.

Invariants (assert in bench):
- count never exceeds DEPTH and never underflows.
- occupancy == count.

Test Plan:
- Reset: pulse reset_n low mid-cycle with count=5 -> immediately count=0, out0_valid=0, in_ready=1, with no clock edge required.
- Fill: push pairs (0x11111111,0x22222222,pc 0x00), (0x33333333,0x44444444,pc 0x08) and two more with deq_count=0 -> count=8, in_ready=0 after the 4th. A 5th in_valid is dropped and count stays 8. out0 shows 0x11111111/pc 0x00 and out1 shows 0x22222222/pc 0x04.
- Mixed: from count=7 (in_ready=0) dequeue 1 -> count=6, in_ready=1. Next cycle push a pair and dequeue 2 simultaneously -> count=6, head advanced by 2.
- Wrap: cycle 20 pairs through with deq_count=2 every cycle, in_pc advancing by 8 from 0xF0 -> output order and instructions match input order exactly. The PC sequence goes ..., 0xF8, 0xFC, 0x00, 0x04 across the PC wrap.
- Flush: count=6, assert flush together with in_valid=1 and deq_count=2 -> next cycle count=0, out0_valid=0, and none of the flushed or incoming instructions ever appear on the outputs.
- Over-dequeue: count=1 with deq_count=2 (and separately deq_count=3) -> count=0, no underflow, head advanced by exactly 1.
